p405s_mmu_real_attr_sel: RTL
============================

// Module: p405s_mmu_real_attr_sel
// PURPOSE
//  Parametrised real-mode storage-attribute selector for the MMU. Selects, per attribute SPR,
//  the 1-of-REGIONS attribute bit addressed by the effective address, in two steps:
//  - Early EA bits pick a group that is registered in the cycle before the access.
//  - Late EA bits pick the bit within that group combinationally.
//  Extends the fixed 2-SPR/32-region selector with:
//  - any SPR count and region count;
//  - a hold/flush handshake;
//  - coherent refresh of the captured group when an attribute SPR is rewritten.
// PARAMETERS
//  NUM_ATTR    2   attribute SPRs looked up in parallel (e.g. cacheability, guarded)
//  REGIONS     32  regions per SPR; power of two, >= 2
//  EARLY_BITS  2   EA bits used at capture; 1 <= EARLY_BITS < log2(REGIONS)
//  Derived: LATE_BITS = log2(REGIONS) - EARLY_BITS; GRP = 2**LATE_BITS bits per group
// PORTS
//  CB          in   1                  clock; all state updates on rising edge
//  reset_N     in   1                  asynchronous active-low reset
//  realEn      in   1                  1 = real-mode translation active; capture permitted
//  reqVal      in   1                  early request; eaEarly valid this cycle
//  eaEarly     in   EARLY_BITS         EA group index, MSB = EA bit 0
//  eaLate_N    in   LATE_BITS          active-low late EA bits selecting bit within group
//  hold        in   1                  pipeline stall; freeze captured state
//  flush       in   1                  discard captured group (context change)
//  sprIn       in   NUM_ATTR*REGIONS   SPR s occupies bits [s*REGIONS +: REGIONS]; bit 0 of each = region 0
//  sprUpd      in   NUM_ATTR           SPR s changed; sprIn holds the new value this cycle
//  attrReal_N  out  NUM_ATTR           active-low selected attribute, one per SPR
//  sliceVal    out  1                  captured group valid
// BEHAVIOUR
//  - Reset (async, reset_N=0):
//    - idx=0, slice[s]=0 for all s, sliceVal=0.
//    - Hence attrReal_N = all 1s (no attribute) immediately, independent of CB.
//  - Per-edge priority, highest first:
//    1. flush: sliceVal<=0; idx and slice unchanged.
//    2. hold: idx, slice, sliceVal unchanged, including sprUpd refresh.
//       The SPR update is lost; the controller must not stall across an SPR write.
//    3. capture, when reqVal & realEn:
//       - idx<=eaEarly;
//       - slice[s]<=sprIn SPR s bits [eaEarly*GRP +: GRP] for every s;
//       - sliceVal<=1.
//       - A same-cycle sprUpd is already covered because capture samples the new sprIn.
//    4. refresh, for each s with sprUpd[s]=1:
//       - slice[s]<=sprIn SPR s bits [idx*GRP +: GRP], using the stored idx;
//       - sliceVal unchanged.
//    5. Otherwise hold all state. realEn=0 or reqVal=0 retains the last group.
//  - Late select (combinational, zero latency):
//    - l = ~eaLate_N, unsigned.
//    - attrReal_N[s] = sliceVal ? ~slice[s][l] : 1, where slice bit 0 = lowest region of the group.
//  - Latency: eaEarly to attrReal_N is 1 cycle; eaLate_N to attrReal_N is combinational.
//  - Wrap-around: eaEarly all-1s selects the last group (regions REGIONS-GRP .. REGIONS-1).
//    No index wraps beyond it.
//  - Reset mid-request: the capture is discarded; the next edge after reset release behaves as from idle.
//  - X on eaEarly or sprIn during a capture propagates to slice. X is never generated internally.
// TESTING
//  1. Reset check:
//     - Stimulus: reset_N=0, all sprIn=1s.
//     - Required: attrReal_N=2'b11, sliceVal=0; sliceVal stays 0 until the first reqVal&realEn edge.
//  2. Defaults, SPR0=32'h8000_0001:
//     - Stimulus: capture eaEarly=0 with eaLate_N=3'b111; then recapture eaEarly=3 with eaLate_N=3'b000.
//     - Required: attrReal_N[0]=0 both times; all other late values give 1.
//  3. Coherent refresh:
//     - Stimulus: capture eaEarly=1; next cycle sprUpd=2'b10 with SPR1 bit 9 newly set; then eaLate_N=3'b110.
//     - Required: attrReal_N[1]=0 on the cycle after sprUpd.
//  4. Priority:
//     - Stimulus a: hold=1 with reqVal=1 and eaEarly=2. Required: idx and outputs unchanged.
//     - Stimulus b: flush=1 with reqVal=1. Required: sliceVal=0, attrReal_N=all 1s.
//  5. realEn=0 retention:
//     - Stimulus: reqVal pulses with a new eaEarly.
//     - Required: the prior group is retained; attrReal_N follows eaLate_N within the old group.
//  6. Parameter sweep: NUM_ATTR=4, REGIONS=64, EARLY_BITS=3.
//     - Stimulus: random sprIn, EA and control.
//     - Required: attrReal_N matches the reference model (flat 1-of-64 lookup, ~spr[s][ea]) every cycle sliceVal=1.

Source files
------------

// File: rtl/p405s_mmu_real_attr_sel.sv
// Real-mode storage-attribute selector: registers one group of each attribute
// SPR from the early EA bits, then picks the region bit with the late EA bits.
//
// Ports:
//   CB, reset_N     clock, async active-low reset
//   realEn, reqVal  capture enable (both high) for eaEarly
//   eaEarly         group index, captured on the rising edge
//   eaLate_N        active-low bit-within-group select (combinational)
//   hold, flush     stall (freeze all state) / discard captured group
//   sprIn, sprUpd   packed attribute SPRs, per-SPR rewrite strobe
//   attrReal_N      active-low selected attribute per SPR
//   sliceVal        captured group valid
module p405s_mmu_real_attr_sel #(
    parameter int NUM_ATTR   = 2,
    parameter int REGIONS    = 32,
    parameter int EARLY_BITS = 2,
    localparam int LATE_BITS = $clog2(REGIONS) - EARLY_BITS,
    localparam int GRP       = 1 << LATE_BITS
) (
    input  logic                        CB,
    input  logic                        reset_N,
    input  logic                        realEn,
    input  logic                        reqVal,
    input  logic [EARLY_BITS-1:0]       eaEarly,
    input  logic [LATE_BITS-1:0]        eaLate_N,
    input  logic                        hold,
    input  logic                        flush,
    input  logic [NUM_ATTR*REGIONS-1:0] sprIn,
    input  logic [NUM_ATTR-1:0]         sprUpd,
    output logic [NUM_ATTR-1:0]         attrReal_N,
    output logic                        sliceVal
);

    localparam int NGRP = 1 << EARLY_BITS;

    typedef logic [GRP-1:0] grp_t;

    logic [EARLY_BITS-1:0] idx;
    grp_t                  slice  [NUM_ATTR];
    grp_t                  capGrp [NUM_ATTR];
    grp_t                  refGrp [NUM_ATTR];
    logic [LATE_BITS-1:0]  lateSel;
    logic                  capture;

    assign capture = reqVal & realEn;
    assign lateSel = ~eaLate_N;

    // AND-OR group muxes: capGrp follows the incoming EA (so a same-cycle
    // SPR write is sampled directly), refGrp follows the stored index.
    always_comb begin
        for (int s = 0; s < NUM_ATTR; s++) begin
            capGrp[s] = '0;
            refGrp[s] = '0;
            for (int g = 0; g < NGRP; g++) begin
                capGrp[s] = capGrp[s]
                    | (sprIn[s*REGIONS + g*GRP +: GRP]
                       & {GRP{eaEarly == EARLY_BITS'(g)}});
                refGrp[s] = refGrp[s]
                    | (sprIn[s*REGIONS + g*GRP +: GRP]
                       & {GRP{idx == EARLY_BITS'(g)}});
            end
        end
    end

    // Priority: flush > hold > capture > per-SPR refresh.
    // A refresh arriving under hold is dropped.
    always_ff @(posedge CB or negedge reset_N) begin
        if (!reset_N) begin
            idx      <= '0;
            slice    <= '{default: '0};
            sliceVal <= 1'b0;
        end else if (flush) begin
            sliceVal <= 1'b0;
        end else if (hold) begin
            sliceVal <= sliceVal;
        end else if (capture) begin
            idx      <= eaEarly;
            slice    <= capGrp;
            sliceVal <= 1'b1;
        end else begin
            for (int s = 0; s < NUM_ATTR; s++) begin
                if (sprUpd[s]) begin
                    slice[s] <= refGrp[s];
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_ATTR; s++) begin
            attrReal_N[s] = sliceVal ? ~slice[s][lateSel] : 1'b1;
        end
    end

endmodule
